lsu_rmw: RTL
============

Name: lsu_rmw

Overview:
- Load/store unit between the core datapath and the word-only synchronous data memory: mem_req/we, 32-bit word address, 1-cycle registered read data, no byte enables.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word transactions.
- Loads: byte/halfword extraction plus sign or zero extension.
- SB/SH: read-modify-write.
- Stalls the core with core_stall_o until each access completes.

Parameters:
- none (data width fixed at 32, memory read latency fixed at 1 cycle)

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  access request; held stable by core while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data; byte/half taken from bits [7:0]/[15:0]
- core_rd_o  out  32  extended load result, valid only in DONE after a load, else 0
- core_stall_o  out  1  1 = hold pipeline
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  {addr[31:2],2'b00}
- mem_wd_o  out  32  full word to write
- mem_rd_i  in  32  memory read data, valid the cycle after a read request

Behaviour:
- Reset:
  - rst_i forces IDLE; request latches cleared.
  - All outputs 0 while rst_i=1; mem_req_o gated by ~rst_i.
  - Reset mid-operation abandons the access: no further mem request; next state is IDLE.
- FSM states: IDLE, LD_RESP, RMW_WR, DONE.
- IDLE:
  - core_req_i=0: all outputs 0, stay IDLE.
  - Request is latched: addr, size, we, wd.
  - Load, or SB/SH: mem_req_o=1, mem_we_o=0, core_stall_o=1. Load -> LD_RESP; SB/SH -> RMW_WR.
  - SW: mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, core_stall_o=1 -> DONE.
- LD_RESP:
  - mem_req_o=0, core_stall_o=1 -> DONE.
  - Extracted result is captured from mem_rd_i into a register.
- RMW_WR:
  - mem_req_o=1, mem_we_o=1, core_stall_o=1 -> DONE.
  - mem_wd_o = mem_rd_i with the target lane replaced:
    - SB: byte lane addr[1:0] <- wd[7:0]
    - SH: half lane addr[1] <- wd[15:0]
  - Merge is combinational from mem_rd_i.
- DONE:
  - core_stall_o=0, mem_req_o=0.
  - core_rd_o = captured result for loads, 0 for stores.
  - Always -> IDLE, even if core_req_i is still high.
  - The core advances on this edge.
- Latency, cycles from request to stall release:
  - Load: 2 (stall high 2 cycles).
  - SW: 1 (stall high 1 cycle).
  - SB/SH: 2 (stall high 2 cycles).
  - Back-to-back requests are accepted in the IDLE cycle following DONE.
- Extraction:
  - LB/LBU: byte addr[1:0], sign/zero extended.
  - LH/LHU: half addr[1], sign/zero extended.
  - LW: whole word.
- Out-of-range addresses:
  - mem_rd_i=0xDEADBEEF is passed through extraction unchanged.
  - LW returns 0xDEADBEEF; LB at offset 0 returns 0xFFFFFFEF.
  - RMW write proceeds; memory ignores it.
- Misalignment without macro: low address bits beyond the access size are ignored (LH uses addr[1] only; LW/SW use the aligned word).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output core_misalign_o (1 bit).
  - A misaligned access (H with addr[0]=1; W with addr[1:0]!=0) issues no memory request.
  - IDLE -> DONE with core_stall_o=1 for 1 cycle.
  - In DONE: core_misalign_o=1 and core_rd_o=0.
  - core_misalign_o is 0 in all other cycles and during reset.
- Undefined: port absent; low-bit truncation as above.

Test Plan:
- SW addr 0x10 wd 0x11223344, then LW 0x10:
  - Store: stall high 1 cycle.
  - Load: stall high 2 cycles; DONE core_rd_o=0x11223344.
- SB addr 0x12 wd 0xAA over word 0x11223344:
  - IDLE cycle: read issued.
  - RMW_WR cycle: mem_wd_o=0x11AA3344, mem_we_o=1.
  - Subsequent LBU 0x12 returns 0x000000AA; LB 0x12 returns 0xFFFFFFAA.
- SH addr 0x16 wd 0x8001 over word 0x00000000:
  - Written word 0x80010000.
  - LH 0x16 returns 0xFFFF8001; LHU 0x16 returns 0x00008001.
- LW addr 0x00004000 (out of range): core_rd_o=0xDEADBEEF in DONE; stall released after 2 cycles.
- rst_i asserted in RMW_WR cycle of an SB:
  - Next cycle state IDLE, all outputs 0.
  - A following LW of that word returns the pre-SB value.
- With LSU_MISALIGN_TRAP_EN:
  - LW addr 0x13: no mem_req_o pulse; stall 1 cycle; core_misalign_o=1 in DONE.
- Without LSU_MISALIGN_TRAP_EN:
  - LW addr 0x13 reads word 0x10.

Source files
------------

// File: rtl/lsu_rmw.sv
// Load/store unit that maps RISC-V byte/half/word accesses onto a word-only memory
// (sub-word stores use read-modify-write). Optional trap build: LSU_MISALIGN_TRAP_EN.
module lsu_rmw (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        core_misalign_o,
`endif
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, LD_RESP, RMW_WR, DONE} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [15:0] wd_q;
  logic [31:0] rd_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        mis_q;

  logic size_byte, size_half, size_word, misaligned;

  assign size_byte = (core_size_i[1:0] == 2'b00);
  assign size_half = (core_size_i[1:0] == 2'b01);
  assign size_word = !size_byte && !size_half;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (size_half && core_addr_i[0]) ||
                      (size_word && (core_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // funct3[2] selects zero extension; funct3[1:0] selects the access width.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] sz,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz[1:0])
      2'b00:   return sz[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return sz[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] sz,
                                        input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (sz[1:0] == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
    else                  r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (core_req_i) begin
          addr_q <= core_addr_i;
          wd_q   <= core_wd_i[15:0];
          size_q <= core_size_i;
          we_q   <= core_we_i;
          mis_q  <= misaligned;
          if (misaligned)                  state_q <= DONE;
          else if (!core_we_i)             state_q <= LD_RESP;
          else if (size_word)              state_q <= DONE;
          else                             state_q <= RMW_WR;
        end
        LD_RESP: begin
          rd_q    <= extract(mem_rd_i, size_q, addr_q[1:0]);
          state_q <= DONE;
        end
        RMW_WR:  state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend on the live request in IDLE, so they are decoded combinationally
  // and forced to zero while reset is held.
  always_comb begin
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    core_misalign_o = 1'b0;
`endif
    if (!rst_i) begin
      case (state_q)
        IDLE: if (core_req_i) begin
          core_stall_o = 1'b1;
          if (!misaligned) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {core_addr_i[31:2], 2'b00};
            if (core_we_i && size_word) begin
              mem_we_o = 1'b1;
              mem_wd_o = core_wd_i;
            end
          end
        end
        LD_RESP: core_stall_o = 1'b1;
        RMW_WR: begin
          core_stall_o = 1'b1;
          mem_req_o    = 1'b1;
          mem_we_o     = 1'b1;
          mem_addr_o   = {addr_q[31:2], 2'b00};
          mem_wd_o     = merge(mem_rd_i, size_q, addr_q[1:0], wd_q);
        end
        default: begin
          core_rd_o = (we_q || mis_q) ? 32'h0 : rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
          core_misalign_o = mis_q;
`endif
        end
      endcase
    end
  end

endmodule
